// File: rtl/output_memory_wrapper.sv
// Result writer: a dot-product result is captured, committed to a circular write
// pointer on processing_done, and can be read back synchronously at any time.
module output_memory_wrapper #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int MEM_SIZE     = 64,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RESULT_WIDTH-1:0] dot_product_result,
  input  logic                    result_valid,
  input  logic                    processing_done,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   result_out,
  output logic                    writer_busy,
  output logic                    writer_done
);

  localparam int MEM_AW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int ADDR_SPAN = 1 << ADDR_WIDTH;
  localparam int PTR_DEPTH = (MEM_SIZE < ADDR_SPAN) ? MEM_SIZE : ADDR_SPAN;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(PTR_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } wr_state_t;

  wr_state_t               state;
  logic [ADDR_WIDTH-1:0]   write_ptr;
  logic [DATA_WIDTH-1:0]   hold_data_p0;
  logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];
  logic                    capture;
  logic                    commit;
  logic                    rd_in_range;
  logic [MEM_AW-1:0]       rd_idx;
  logic [MEM_AW-1:0]       wr_idx;
  logic                    unused_result_hi;

  // Plain truncation: the upper result bits are dropped, never saturated.
  function automatic logic [DATA_WIDTH-1:0] trunc_result(
    input logic [RESULT_WIDTH-1:0] r
  );
    return r[DATA_WIDTH-1:0];
  endfunction

  assign capture          = (state != BUSY) && result_valid;
  assign commit           = (state == BUSY) && processing_done;
  assign rd_in_range      = $unsigned(32'(read_addr)) < $unsigned(32'(MEM_SIZE));
  assign rd_idx           = MEM_AW'(read_addr);
  assign wr_idx           = MEM_AW'(write_ptr);
  assign unused_result_hi = ^dot_product_result[RESULT_WIDTH-1:DATA_WIDTH];

  // Writer FSM; status outputs are registered together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      write_ptr    <= '0;
      hold_data_p0 <= '0;
      writer_busy  <= 1'b0;
      writer_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (capture) begin
            hold_data_p0 <= trunc_result(dot_product_result);
            state        <= BUSY;
            writer_busy  <= 1'b1;
            writer_done  <= 1'b0;
          end
        end
        BUSY: begin
          if (commit) begin
            write_ptr   <= (write_ptr == PTR_LAST) ? '0 : write_ptr + 1'b1;
            state       <= DONE;
            writer_busy <= 1'b0;
            writer_done <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          writer_busy <= 1'b0;
          writer_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage and read port; a same-edge read of the write address sees old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= '0;
      end
      result_out <= '0;
    end else begin
      if (commit) begin
        mem[wr_idx] <= hold_data_p0;
      end
      if (read_en) begin
        result_out <= rd_in_range ? mem[rd_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_output_memory_wrapper.sv
// Bench for output_memory_wrapper: vector table of commits plus hand-written
// corner sequences, with read expectations queued at request and checked on return.
module tb_output_memory_wrapper;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] dot_product_result;
  logic          result_valid;
  logic          processing_done;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] result_out;
  logic          writer_busy;
  logic          writer_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [RW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  output_memory_wrapper dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .dot_product_result (dot_product_result),
    .result_valid       (result_valid),
    .processing_done    (processing_done),
    .read_en            (read_en),
    .read_addr          (read_addr),
    .result_out         (result_out),
    .writer_busy        (writer_busy),
    .writer_done        (writer_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All tasks start just after a falling edge and end just after one.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic capture(input logic [RW-1:0] v);
    result_valid       = 1'b1;
    dot_product_result = v;
    @(negedge clk);
    result_valid       = 1'b0;
  endtask

  task automatic pulse_done();
    processing_done = 1'b1;
    @(negedge clk);
    processing_done = 1'b0;
  endtask

  task automatic commit(input logic [RW-1:0] v);
    capture(v);
    pulse_done();
  endtask

  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_exp_t e;
    read_en   = 1'b1;
    read_addr = a;
    sb_q.push_back('{addr: a, exp: exp});
    @(negedge clk);
    read_en = 1'b0;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue at read return");
    end else begin
      e = sb_q.pop_front();
      check($sformatf("read[%0d]", e.addr), 32'(result_out), 32'(e.exp));
    end
  endtask

  initial begin
    vec_t vecs[7];
    rd_exp_t e;
    logic [DW-1:0] held;

    vecs[0] = '{din: 18'd10,   exp: 8'd10};
    vecs[1] = '{din: 18'd15,   exp: 8'd15};
    vecs[2] = '{din: 18'd20,   exp: 8'd20};
    vecs[3] = '{din: 18'd0,    exp: 8'd0};
    vecs[4] = '{din: 18'd255,  exp: 8'd255};
    vecs[5] = '{din: 18'd1024, exp: 8'd0};
    vecs[6] = '{din: 18'd300,  exp: 8'd44};

    rst_n = 1'b0;
    dot_product_result = '0;
    result_valid = 1'b0;
    processing_done = 1'b0;
    read_en = 1'b0;
    read_addr = '0;
    @(negedge clk);
    do_reset();
    check("reset result_out", 32'(result_out), 0);
    check("reset busy", 32'(writer_busy), 0);
    check("reset done", 32'(writer_done), 0);

    // Basic capture / commit / read of 42
    capture(18'd42);
    check("busy after capture", 32'(writer_busy), 1);
    check("done after capture", 32'(writer_done), 0);
    pulse_done();
    check("done after commit", 32'(writer_done), 1);
    check("busy after commit", 32'(writer_busy), 0);
    read_check(4'd0, 8'd42);

    // processing_done in IDLE must not write or advance the pointer
    do_reset();
    pulse_done();
    check("idle pd busy", 32'(writer_busy), 0);
    check("idle pd done", 32'(writer_done), 0);
    commit(18'd5);
    read_check(4'd0, 8'd5);
    read_check(4'd1, 8'd0);

    // Table of commits from a fresh reset, including truncation cases
    do_reset();
    foreach (vecs[i]) commit(vecs[i].din);
    foreach (vecs[i]) read_check(AW'(i), vecs[i].exp);

    // read_en low holds the last value while the address moves
    read_addr = 4'd2;
    @(negedge clk);
    check("hold with read_en=0", 32'(result_out), 44);

    // result_valid while BUSY is ignored; first value is stored
    capture(18'd77);
    capture(18'd99);
    check("busy after 2nd valid", 32'(writer_busy), 1);
    pulse_done();
    read_check(4'd7, 8'd77);
    // processing_done in DONE ignored
    pulse_done();
    check("done persists after pd", 32'(writer_done), 1);
    commit(18'd33);
    read_check(4'd8, 8'd33);
    read_check(4'd9, 8'd0);

    // valid and processing_done together in DONE: capture only
    result_valid = 1'b1;
    processing_done = 1'b1;
    dot_product_result = 18'd66;
    @(negedge clk);
    result_valid = 1'b0;
    processing_done = 1'b0;
    check("rv+pd busy", 32'(writer_busy), 1);
    read_check(4'd9, 8'd0);
    pulse_done();
    read_check(4'd9, 8'd66);

    // 17 commits: pointer wraps and the 17th overwrites address 0
    do_reset();
    for (int i = 0; i < 17; i++) begin
      commit(RW'(i + 1));
      @(negedge clk);
      @(negedge clk);
      check($sformatf("done held %0d", i), 32'(writer_done), 1);
    end
    read_check(4'd0, 8'd17);
    read_check(4'd1, 8'd2);
    read_check(4'd15, 8'd16);

    // Same-edge read and write of address 1 returns old contents
    capture(18'd200);
    held = 8'd2;
    processing_done = 1'b1;
    read_en = 1'b1;
    read_addr = 4'd1;
    sb_q.push_back('{addr: 4'd1, exp: held});
    @(negedge clk);
    processing_done = 1'b0;
    read_en = 1'b0;
    e = sb_q.pop_front();
    check("rd/wr collision old", 32'(result_out), 32'(e.exp));
    read_check(4'd1, 8'd200);

    // Reset in the middle of BUSY discards the pending result
    capture(18'd123);
    check("busy before reset", 32'(writer_busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid reset busy", 32'(writer_busy), 0);
    check("mid reset done", 32'(writer_done), 0);
    check("mid reset result_out", 32'(result_out), 0);
    for (int a = 0; a < 16; a++) read_check(AW'(a), 8'd0);
    commit(18'd9);
    read_check(4'd0, 8'd9);
    read_check(4'd2, 8'd0);

    check("scoreboard drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_memory_wrapper.md
OUTPUT_MEMORY_WRAPPER -- requirements
Module: output_memory_wrapper

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of a stored/read result word.
REQ-002 The block SHALL have parameter VECTOR_WIDTH, default 4: dot-product vector length; used only to size RESULT_WIDTH.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4: width of the read address and the write pointer.
REQ-004 The block SHALL have parameter MEM_SIZE, default 64: memory depth in words.
REQ-005 The block SHALL have parameter RESULT_WIDTH, default 2*DATA_WIDTH+clog2(VECTOR_WIDTH) (18): width of the incoming result.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port dot_product_result, input, RESULT_WIDTH bits: result to store.
REQ-009 The block SHALL have port result_valid, input, 1 bit: dot_product_result is valid this cycle.
REQ-010 The block SHALL have port processing_done, input, 1 bit: commit the captured result to memory.
REQ-011 The block SHALL have port read_en, input, 1 bit: read request.
REQ-012 The block SHALL have port read_addr, input, ADDR_WIDTH bits: read address.
REQ-013 The block SHALL have port result_out, output, DATA_WIDTH bits: registered read data.
REQ-014 The block SHALL have port writer_busy, output, 1 bit: a result is captured and awaiting commit.
REQ-015 The block SHALL have port writer_done, output, 1 bit: the last captured result has been committed.

Function
REQ-016 The writer SHALL be an FSM with states IDLE, BUSY and DONE; writer_busy=1 only in BUSY and writer_done=1 only in DONE, both decoded from registered state.
REQ-017 In IDLE or DONE, a sampled result_valid=1 SHALL latch dot_product_result[DATA_WIDTH-1:0] (upper bits discarded, no saturation) into a holding register and move the FSM to BUSY at that edge.
REQ-018 In BUSY, result_valid SHALL be ignored, and the holding register SHALL NOT change.
REQ-019 In BUSY, a sampled processing_done=1 SHALL write the holding register to memory at write_ptr, increment write_ptr, and move the FSM to DONE at that same edge.
REQ-020 DONE SHALL persist, holding writer_done=1, until the next accepted result_valid, which moves the FSM directly to BUSY.
REQ-021 processing_done SHALL be ignored in IDLE and DONE; if result_valid and processing_done are both 1 in IDLE/DONE, only the capture SHALL occur.
REQ-022 write_ptr SHALL be ADDR_WIDTH bits, start at 0, and wrap to 0 after min(MEM_SIZE, 2^ADDR_WIDTH)-1; with the defaults, writes land at addresses 0..15 and then wrap.
REQ-023 Reads SHALL be synchronous: on an edge with read_en=1, result_out SHALL load mem[read_addr], valid the cycle after the request.
REQ-024 If read_addr >= MEM_SIZE, the read SHALL return 0.
REQ-025 With read_en=0, result_out SHALL hold its previous value.
REQ-026 Reads SHALL be independent of the FSM state and allowed at any time.
REQ-027 A read and a write to the same address on the same edge SHALL return the old contents.

Reset
REQ-028 On an edge with rst_n=0, the block SHALL set FSM=IDLE, write_ptr=0, holding register=0, result_out=0, writer_busy=0, writer_done=0, and clear all memory words to 0.
REQ-029 Reset SHALL take priority over all other inputs; a reset in BUSY SHALL discard the pending result with no memory write.

Verification
REQ-030 After reset: pulse result_valid with 42; check writer_busy=1 the next cycle; pulse processing_done; check writer_done=1 and writer_busy=0; then read_en with addr 0 must give result_out=42 one cycle later.
REQ-031 From reset: commit 10, 15, 20 in sequence; reads of addresses 0, 1, 2 must return 10, 15, 20.
REQ-032 Commit 0, 255, 1024 and 300; they must read back as 0, 255, 0 and 44 (low 8 bits).
REQ-033 Pulse result_valid again while BUSY with a different value; the commit must store the first value, and processing_done sent in IDLE must write nothing.
REQ-034 Perform 17 commits; commit 17 must overwrite address 0, and writer_done must stay 1 between commits until the next result_valid.
REQ-035 Assert rst_n=0 mid-BUSY; outputs must go to 0; all addresses must read 0; the next commit must go to address 0.
